regfile_scoreboard: RTL and testbench
=====================================

REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

Interface
REQ-001 Parameter XLEN, default 64: data width of every architectural register.
REQ-002 Parameter NREGS, default 32: number of architectural registers, indexed by 5-bit addresses.
REQ-003 clk  in  1  clock; all state updates on the rising edge.
REQ-004 reset  in  1  reset, synchronous, active-high.
REQ-005 wb_write_enable  in  1  write-back request from the write-back stage.
REQ-006 wb_write_reg  in  5  write-back destination register.
REQ-007 wb_write_data  in  XLEN  write-back data.
REQ-008 rs1_addr, rs2_addr  in  5 each  decode-stage source register addresses.
REQ-009 rs1_data, rs2_data  out  XLEN each  source operand values.
REQ-010 issue_valid  in  1  decode is presenting an instruction for issue.
REQ-011 issue_writes_rd  in  1  the presented instruction writes a destination register.
REQ-012 issue_dest_reg  in  5  destination of the presented instruction.
REQ-013 flush  in  1  pipeline flush; discards all in-flight writes.
REQ-014 hazard  out  1  the presented instruction must stall this cycle.
REQ-015 issue_accept  out  1  the presented instruction issues this cycle.
REQ-016 pending_mask  out  NREGS  per-register pending-write bits, for debug and verification.

Function
REQ-017 Register x0 shall always read 0, shall never be written, and shall never be marked pending.
REQ-018 A write shall occur at the clock edge when wb_write_enable=1 and wb_write_reg!=0; the request is ignored when wb_write_reg=0.
REQ-019 Reads shall be combinational, with write-first bypass: when the read address equals an enabled nonzero wb_write_reg in the same cycle, the read returns wb_write_data.
REQ-020 Each register shall hold one pending bit; there is at most one in-flight writer per register.
REQ-021 Effective busy(r) = pending[r] and not (wb_write_enable and wb_write_reg==r and r!=0); a write-back in the current cycle clears the hazard in that same cycle.
REQ-022 hazard = issue_valid and (busy(rs1_addr) or busy(rs2_addr) or (issue_writes_rd and busy(issue_dest_reg))); this is combinational.
REQ-023 issue_accept = issue_valid and not hazard and not flush.
REQ-024 The pending bit of wb_write_reg shall clear at the edge on every write-back with wb_write_enable=1.
REQ-025 The pending bit of issue_dest_reg shall set at the edge on issue_accept=1 with issue_writes_rd=1 and issue_dest_reg!=0.
REQ-026 When a set and a clear target the same register in the same cycle, the set shall win and the register ends pending=1.
REQ-027 On flush=1, all pending bits shall clear at the edge, including any set requested that cycle; a write-back in the same cycle still writes the data array.
REQ-028 Write-back for a register that is not pending shall still write the data and shall leave pending=0; this is not an error.
REQ-029 Issue-to-hazard latency: an issued destination shall be busy starting the next cycle.
REQ-030 Write-back-to-readable latency: 0 cycles via bypass; the stored value is visible from the array on the next cycle.

Reset
REQ-031 While reset=1 at an edge, all data registers shall clear to 0 and all pending bits shall clear to 0; write and issue requests in that cycle are ignored.
REQ-032 The outputs shall remain combinational during reset; after the reset edge, rs1_data=rs2_data=0, pending_mask=0, and hazard=0.
REQ-033 Reset shall take priority over flush, write-back, and issue.

Verification
REQ-034 Reset, then write x5=0xDEAD_BEEF; next cycle rs1_addr=5 -> rs1_data=0xDEADBEEF. Write to x0 with 0x1 -> x0 reads 0 and pending_mask[0]=0.
REQ-035 Same-cycle bypass: wb x7=0x1234 with rs2_addr=7 in the same cycle -> rs2_data=0x1234 before the edge.
REQ-036 Issue dest x3 at cycle N; at N+1 present rs1=3 -> hazard=1 and issue_accept=0; at N+3 wb x3 -> hazard=0 and issue_accept=1 in that cycle.
REQ-037 Issue with dest x4 in the same cycle as wb x4 (x4 pending) -> at the edge pending_mask[4]=1 and issue_accept=1.
REQ-038 Pending x2, x9, x31, then flush=1 together with issue dest x6 -> pending_mask=0 next cycle; a simultaneous wb x9=0x55 lands in the array.
REQ-039 Assert reset mid-operation with x10 pending and x10=0xFF -> next cycle x10 reads 0, pending_mask=0, and hazard=0.

Source files
------------

// File: rtl/regfile_scoreboard_if.sv
// ---------------------------------------------------------------------------
// regfile_scoreboard_if
//
// Bundles the write-back, operand-read and issue/scoreboard signals of the
// integer register file so the pipeline and the register file connect with
// one port.
//
// Ports (signals inside the bundle):
//   wb_write_enable / wb_write_reg / wb_write_data : write-back request
//   rs1_addr / rs2_addr                            : decode read addresses
//   rs1_data / rs2_data                            : operand values
//   issue_valid / issue_writes_rd / issue_dest_reg : instruction at issue
//   flush                                          : discard in-flight writes
//   hazard / issue_accept                          : issue stall / issue fire
//   pending_mask                                   : per-register pending bits
//
// Modports:
//   master : the pipeline side (drives requests, observes results)
//   slave  : the register file itself
// ---------------------------------------------------------------------------
interface regfile_scoreboard_if #(
    parameter int XLEN  = 64,
    parameter int NREGS = 32
);
    logic              wb_write_enable;
    logic [4:0]        wb_write_reg;
    logic [XLEN-1:0]   wb_write_data;

    logic [4:0]        rs1_addr;
    logic [4:0]        rs2_addr;
    logic [XLEN-1:0]   rs1_data;
    logic [XLEN-1:0]   rs2_data;

    logic              issue_valid;
    logic              issue_writes_rd;
    logic [4:0]        issue_dest_reg;
    logic              flush;

    logic              hazard;
    logic              issue_accept;
    logic [NREGS-1:0]  pending_mask;

    modport master (
        output wb_write_enable, wb_write_reg, wb_write_data,
        output rs1_addr, rs2_addr,
        output issue_valid, issue_writes_rd, issue_dest_reg, flush,
        input  rs1_data, rs2_data, hazard, issue_accept, pending_mask
    );

    modport slave (
        input  wb_write_enable, wb_write_reg, wb_write_data,
        input  rs1_addr, rs2_addr,
        input  issue_valid, issue_writes_rd, issue_dest_reg, flush,
        output rs1_data, rs2_data, hazard, issue_accept, pending_mask
    );
endinterface

// File: rtl/regfile_scoreboard.sv
// ---------------------------------------------------------------------------
// regfile_scoreboard
//
// Architectural register file (x0 hardwired to zero) with a one-bit-per-
// register pending-write scoreboard used by decode to detect RAW/WAW hazards.
//
// Ports:
//   clk   : clock, all state updates on the rising edge
//   reset : synchronous, active-high; clears data and pending bits
//   bus   : regfile_scoreboard_if.slave (write-back, reads, issue, flush,
//           hazard, issue_accept, pending_mask)
//
// Issue handshake: issue_valid is decode's offer of an instruction; it issues
// in exactly the cycle where issue_accept=1, i.e. issue_valid with no hazard
// and no flush. While hazard=1 decode holds the instruction and re-offers it.
// The scoreboard reservation for the destination is taken at that edge.
//
// The pending bits are the only scoreboard state and are exported as
// pending_mask so checkers can observe them directly.
// ---------------------------------------------------------------------------
module regfile_scoreboard #(
    parameter int XLEN  = 64,
    parameter int NREGS = 32
) (
    input logic                  clk,
    input logic                  reset,
    regfile_scoreboard_if.slave  bus
);

    logic [XLEN-1:0]  regs_q [NREGS];
    logic [XLEN-1:0]  regs_d [NREGS];
    logic [NREGS-1:0] pending_q;
    logic [NREGS-1:0] pending_d;

    logic             wb_hit;        // write-back that actually updates the array
    logic [NREGS-1:0] wb_onehot;     // register targeted by any write-back request
    logic [NREGS-1:0] busy_mask;     // pending bits with same-cycle write-back removed
    logic             rs1_busy;
    logic             rs2_busy;
    logic             rd_busy;
    logic             hazard_c;
    logic             accept_c;

    // -----------------------------------------------------------------------
    // Write-back decode and effective busy vector
    // -----------------------------------------------------------------------
    always_comb begin
        wb_hit    = bus.wb_write_enable && (bus.wb_write_reg != 5'd0);
        wb_onehot = '0;
        if (bus.wb_write_enable) begin
            wb_onehot[bus.wb_write_reg] = 1'b1;
        end
        // A write-back landing this cycle releases its register immediately,
        // so a dependent instruction can issue alongside the write-back and
        // pick the value up through the read bypass.
        busy_mask = pending_q & ~wb_onehot;
    end

    // -----------------------------------------------------------------------
    // Hazard and issue decision (combinational)
    // -----------------------------------------------------------------------
    always_comb begin
        rs1_busy = busy_mask[bus.rs1_addr];
        rs2_busy = busy_mask[bus.rs2_addr];
        rd_busy  = bus.issue_writes_rd && busy_mask[bus.issue_dest_reg];
        hazard_c = bus.issue_valid && (rs1_busy || rs2_busy || rd_busy);
        accept_c = bus.issue_valid && !hazard_c && !bus.flush;
    end

    // -----------------------------------------------------------------------
    // Read ports with write-first bypass
    // -----------------------------------------------------------------------
    always_comb begin
        if (bus.rs1_addr == 5'd0) begin
            bus.rs1_data = '0;
        end else if (wb_hit && (bus.wb_write_reg == bus.rs1_addr)) begin
            bus.rs1_data = bus.wb_write_data;
        end else begin
            bus.rs1_data = regs_q[bus.rs1_addr];
        end

        if (bus.rs2_addr == 5'd0) begin
            bus.rs2_data = '0;
        end else if (wb_hit && (bus.wb_write_reg == bus.rs2_addr)) begin
            bus.rs2_data = bus.wb_write_data;
        end else begin
            bus.rs2_data = regs_q[bus.rs2_addr];
        end
    end

    always_comb begin
        bus.hazard       = hazard_c;
        bus.issue_accept = accept_c;
        bus.pending_mask = pending_q;
    end

    // -----------------------------------------------------------------------
    // Next-state: data array
    // -----------------------------------------------------------------------
    always_comb begin
        for (int i = 0; i < NREGS; i++) begin
            regs_d[i] = regs_q[i];
        end
        // Flush does not stop a write-back: the producing instruction has
        // already committed by the time it reaches write-back.
        if (wb_hit) begin
            regs_d[bus.wb_write_reg] = bus.wb_write_data;
        end
        regs_d[0] = '0;
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_d[i] = '0;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Next-state: pending bits
    // Order of the assignments encodes priority: clear by write-back, then
    // set by issue (set wins on the same register), then flush, then reset.
    // -----------------------------------------------------------------------
    always_comb begin
        pending_d = pending_q & ~wb_onehot;
        if (accept_c && bus.issue_writes_rd && (bus.issue_dest_reg != 5'd0)) begin
            pending_d[bus.issue_dest_reg] = 1'b1;
        end
        if (bus.flush) begin
            pending_d = '0;
        end
        pending_d[0] = 1'b0;
        if (reset) begin
            pending_d = '0;
        end
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        pending_q <= pending_d;
        for (int i = 0; i < NREGS; i++) begin
            regs_q[i] <= regs_d[i];
        end
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
module tb_regfile_scoreboard;

    localparam int XLEN  = 64;
    localparam int NREGS = 32;

    // ---------------- clock / reset ----------------
    logic clk;
    logic reset;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    regfile_scoreboard_if #(.XLEN(XLEN), .NREGS(NREGS)) bus ();

    regfile_scoreboard #(.XLEN(XLEN), .NREGS(NREGS)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int vectors;
    int miscompares;

    // ---------------- reference model ----------------
    // Architectural view: a value per register and a "write outstanding"
    // flag per register, updated once per clock from the rules of the block.
    logic [XLEN-1:0] mem  [NREGS];
    bit              pend [NREGS];

    function automatic bit m_busy(input logic [4:0] r);
        return pend[r] && !(bus.wb_write_enable && bus.wb_write_reg == r && r != 0);
    endfunction

    function automatic logic [XLEN-1:0] m_read(input logic [4:0] a);
        if (a == 0) return '0;
        if (bus.wb_write_enable && bus.wb_write_reg == a) return bus.wb_write_data;
        return mem[a];
    endfunction

    function automatic bit m_hazard();
        return bus.issue_valid && (m_busy(bus.rs1_addr) || m_busy(bus.rs2_addr) ||
               (bus.issue_writes_rd && m_busy(bus.issue_dest_reg)));
    endfunction

    function automatic bit m_accept();
        return bus.issue_valid && !m_hazard() && !bus.flush;
    endfunction

    function automatic logic [NREGS-1:0] m_mask();
        logic [NREGS-1:0] m;
        for (int i = 0; i < NREGS; i++) m[i] = pend[i];
        return m;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic drive_idle();
        bus.wb_write_enable = 1'b0;
        bus.wb_write_reg    = '0;
        bus.wb_write_data   = '0;
        bus.rs1_addr        = '0;
        bus.rs2_addr        = '0;
        bus.issue_valid     = 1'b0;
        bus.issue_writes_rd = 1'b0;
        bus.issue_dest_reg  = '0;
        bus.flush           = 1'b0;
    endtask

    // Advance one clock; the model absorbs the inputs present at the edge.
    task automatic tick();
        bit acc;
        logic w_en, wr, fl, rst;
        logic [4:0] w_reg, dst;
        logic [XLEN-1:0] w_dat;
        acc   = m_accept();
        w_en  = bus.wb_write_enable; w_reg = bus.wb_write_reg; w_dat = bus.wb_write_data;
        wr    = bus.issue_writes_rd; dst   = bus.issue_dest_reg;
        fl    = bus.flush;           rst   = reset;
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin mem[i] = '0; pend[i] = 0; end
        end else begin
            if (w_en && w_reg != 0) mem[w_reg] = w_dat;
            if (w_en) pend[w_reg] = 0;
            if (acc && wr && dst != 0) pend[dst] = 1;
            if (fl) for (int i = 0; i < NREGS; i++) pend[i] = 0;
        end
        #1;
    endtask

    task automatic wb(input logic [4:0] r, input logic [XLEN-1:0] d);
        bus.wb_write_enable = 1'b1;
        bus.wb_write_reg    = r;
        bus.wb_write_data   = d;
    endtask

    task automatic issue_dest(input logic [4:0] r);
        bus.issue_valid     = 1'b1;
        bus.issue_writes_rd = 1'b1;
        bus.issue_dest_reg  = r;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        drive_idle();
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        bus.rs1_addr = 5'd5; bus.rs2_addr = 5'd17; bus.issue_valid = 1'b1;
        #1;
        vectors++;
        if (bus.rs1_data !== '0 || bus.rs2_data !== '0) begin
            miscompares++;
            $display("FAIL reset_data: rs1=%h rs2=%h expected 0", bus.rs1_data, bus.rs2_data);
        end
        vectors++;
        if (bus.pending_mask !== '0) begin
            miscompares++;
            $display("FAIL reset_pending: got %h expected 0", bus.pending_mask);
        end
        vectors++;
        if (bus.hazard !== 1'b0 || bus.issue_accept !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_hazard: hazard=%b accept=%b expected 0/1", bus.hazard, bus.issue_accept);
        end
        drive_idle();
    endtask

    task automatic test_write_read();
        drive_idle();
        wb(5'd5, 64'hDEAD_BEEF);
        tick();
        drive_idle();
        bus.rs1_addr = 5'd5;
        #1;
        vectors++;
        if (bus.rs1_data !== 64'hDEAD_BEEF) begin
            miscompares++;
            $display("FAIL write_read_x5: got %h expected %h", bus.rs1_data, 64'hDEAD_BEEF);
        end
        // x0 ignores writes and reservations
        drive_idle();
        wb(5'd0, 64'h1);
        bus.rs1_addr = 5'd0;
        #1;
        vectors++;
        if (bus.rs1_data !== '0) begin
            miscompares++;
            $display("FAIL x0_bypass: got %h expected 0", bus.rs1_data);
        end
        issue_dest(5'd0);
        tick();
        drive_idle();
        bus.rs2_addr = 5'd0;
        #1;
        vectors++;
        if (bus.rs2_data !== '0 || bus.pending_mask[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL x0_read: data=%h pend0=%b expected 0/0", bus.rs2_data, bus.pending_mask[0]);
        end
    endtask

    task automatic test_bypass();
        drive_idle();
        wb(5'd7, 64'h1234);
        bus.rs2_addr = 5'd7;
        #1;
        vectors++;
        if (bus.rs2_data !== 64'h1234) begin
            miscompares++;
            $display("FAIL bypass_same_cycle: got %h expected %h", bus.rs2_data, 64'h1234);
        end
        tick();
        drive_idle();
        bus.rs2_addr = 5'd7;
        #1;
        vectors++;
        if (bus.rs2_data !== 64'h1234) begin
            miscompares++;
            $display("FAIL bypass_stored: got %h expected %h", bus.rs2_data, 64'h1234);
        end
    endtask

    task automatic test_hazard_sequence();
        drive_idle();
        issue_dest(5'd3);
        #1;
        vectors++;
        if (bus.issue_accept !== 1'b1) begin
            miscompares++;
            $display("FAIL raw_issue: accept=%b expected 1", bus.issue_accept);
        end
        tick();
        for (int c = 1; c <= 3; c++) begin
            drive_idle();
            bus.issue_valid = 1'b1;
            bus.rs1_addr    = 5'd3;
            if (c == 3) wb(5'd3, 64'hABCD);
            #1;
            vectors++;
            if (bus.hazard !== (c != 3) || bus.issue_accept !== (c == 3)) begin
                miscompares++;
                $display("FAIL raw_cycle%0d: hazard=%b accept=%b expected %b/%b",
                         c, bus.hazard, bus.issue_accept, c != 3, c == 3);
            end
            if (c == 3) begin
                vectors++;
                if (bus.rs1_data !== 64'hABCD) begin
                    miscompares++;
                    $display("FAIL raw_bypass: got %h expected %h", bus.rs1_data, 64'hABCD);
                end
            end
            tick();
        end
        drive_idle();
        #1;
        vectors++;
        if (bus.pending_mask !== '0) begin
            miscompares++;
            $display("FAIL raw_release: got %h expected 0", bus.pending_mask);
        end
    endtask

    task automatic test_set_clear_same();
        drive_idle();
        issue_dest(5'd4);
        tick();
        drive_idle();
        issue_dest(5'd4);
        wb(5'd4, 64'h44);
        #1;
        vectors++;
        if (bus.issue_accept !== 1'b1) begin
            miscompares++;
            $display("FAIL waw_accept: got %b expected 1", bus.issue_accept);
        end
        tick();
        drive_idle();
        #1;
        vectors++;
        if (bus.pending_mask !== 32'h0000_0010) begin
            miscompares++;
            $display("FAIL waw_set_wins: got %h expected %h", bus.pending_mask, 32'h10);
        end
        wb(5'd4, 64'h45);
        tick();
        drive_idle();
    endtask

    task automatic test_flush();
        drive_idle();
        issue_dest(5'd2);  tick();
        issue_dest(5'd9);  tick();
        issue_dest(5'd31); tick();
        drive_idle();
        #1;
        vectors++;
        if (bus.pending_mask !== 32'h8000_0204) begin
            miscompares++;
            $display("FAIL flush_before: got %h expected %h", bus.pending_mask, 32'h8000_0204);
        end
        bus.flush = 1'b1;
        issue_dest(5'd6);
        wb(5'd9, 64'h55);
        #1;
        vectors++;
        if (bus.issue_accept !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_accept: got %b expected 0", bus.issue_accept);
        end
        tick();
        drive_idle();
        bus.rs1_addr = 5'd9;
        #1;
        vectors++;
        if (bus.pending_mask !== '0 || bus.rs1_data !== 64'h55) begin
            miscompares++;
            $display("FAIL flush_after: mask=%h x9=%h expected 0/55", bus.pending_mask, bus.rs1_data);
        end
    endtask

    task automatic test_reset_mid();
        drive_idle();
        wb(5'd10, 64'hFF); tick();
        drive_idle();
        issue_dest(5'd10); tick();
        drive_idle();
        #1;
        vectors++;
        if (bus.pending_mask[10] !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_mid_setup: pend10=%b expected 1", bus.pending_mask[10]);
        end
        reset = 1'b1;
        issue_dest(5'd12);
        wb(5'd11, 64'h77);
        tick();
        reset = 1'b0;
        drive_idle();
        bus.rs1_addr = 5'd10; bus.rs2_addr = 5'd11;
        bus.issue_valid = 1'b1;
        #1;
        vectors++;
        if (bus.rs1_data !== '0 || bus.rs2_data !== '0 || bus.pending_mask !== '0 || bus.hazard !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid: x10=%h x11=%h mask=%h hazard=%b expected 0/0/0/0",
                     bus.rs1_data, bus.rs2_data, bus.pending_mask, bus.hazard);
        end
        drive_idle();
    endtask

    task automatic test_random();
        logic [XLEN-1:0] e1, e2;
        bit eh, ea;
        for (int n = 0; n < 400; n++) begin
            reset                = ($urandom_range(0, 59) == 0);
            bus.wb_write_enable  = ($urandom_range(0, 2) == 0);
            bus.wb_write_reg     = 5'($urandom_range(0, 7));
            bus.wb_write_data    = {$urandom, $urandom};
            bus.rs1_addr         = 5'($urandom_range(0, 7));
            bus.rs2_addr         = 5'($urandom_range(0, 9));
            bus.issue_valid      = ($urandom_range(0, 3) != 0);
            bus.issue_writes_rd  = ($urandom_range(0, 3) != 0);
            bus.issue_dest_reg   = 5'($urandom_range(0, 7));
            bus.flush            = ($urandom_range(0, 19) == 0);
            #1;
            e1 = m_read(bus.rs1_addr);
            e2 = m_read(bus.rs2_addr);
            eh = m_hazard();
            ea = m_accept();
            vectors++;
            if (bus.rs1_data !== e1 || bus.rs2_data !== e2) begin
                miscompares++;
                $display("FAIL rand_read[%0d]: rs1=%h rs2=%h expected %h %h", n, bus.rs1_data, bus.rs2_data, e1, e2);
            end
            vectors++;
            if (bus.hazard !== eh || bus.issue_accept !== ea) begin
                miscompares++;
                $display("FAIL rand_issue[%0d]: hazard=%b accept=%b expected %b %b", n, bus.hazard, bus.issue_accept, eh, ea);
            end
            vectors++;
            if (bus.pending_mask !== m_mask()) begin
                miscompares++;
                $display("FAIL rand_pending[%0d]: got %h expected %h", n, bus.pending_mask, m_mask());
            end
            tick();
        end
        reset = 1'b0;
        drive_idle();
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        for (int i = 0; i < NREGS; i++) begin mem[i] = '0; pend[i] = 0; end
        drive_idle();
        @(posedge clk); #1;
        test_reset();
        test_write_read();
        test_bypass();
        test_hazard_sequence();
        test_set_clear_same();
        test_flush();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
